// File: rtl/burst_ram_arbiter.sv
// Two-client arbiter in front of a single BurstRAM port: grants one read or
// write burst at a time and alternates between the clients when both ask at once.
module burst_ram_arbiter #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int BURST_COUNT    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     req_cmd,
  input  logic [1:0]                     req_cmd_en,
  input  logic [2*DEPTH_BITWIDTH-1:0]    req_addr,
  input  logic [2*DATA_BITWIDTH-1:0]     req_wr_data,
  input  logic [2*DATA_BITWIDTH/8-1:0]   req_data_mask,
  output logic [DATA_BITWIDTH-1:0]       req_rd_data,
  output logic [1:0]                     req_rd_data_valid,
  output logic [1:0]                     req_busy,
  output logic                           br_cmd,
  output logic                           br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]      br_addr,
  output logic [DATA_BITWIDTH-1:0]       br_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]     br_data_mask,
  input  logic [DATA_BITWIDTH-1:0]       br_rd_data,
  input  logic                           br_rd_data_valid,
  input  logic                           br_busy
);

  localparam int DW = DATA_BITWIDTH;
  localparam int AW = DEPTH_BITWIDTH;
  localparam int MW = DATA_BITWIDTH / 8;
  localparam int CW = $clog2(BURST_COUNT) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;

  logic tie;
  logic grant;
  logic accept;
  logic sel;

  // On a tie the client that did not own the previous burst wins.
  always_comb begin
    tie      = &req_cmd_en;
    grant    = tie ? ~last_grant_q : req_cmd_en[1];
    accept   = (state_q == IDLE) && !br_busy && (|req_cmd_en) && !rst;
    req_busy = {2{(state_q != IDLE) || br_busy}} | (tie ? {~grant, grant} : 2'b00);
    sel      = (state_q != IDLE) ? owner_q : (accept ? grant : 1'b0);
  end

  always_comb begin
    br_cmd_en    = accept;
    br_cmd       = req_cmd[grant];
    br_addr      = grant ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    br_wr_data   = sel ? req_wr_data[2*DW-1:DW] : req_wr_data[DW-1:0];
    br_data_mask = sel ? req_data_mask[2*MW-1:MW] : req_data_mask[MW-1:0];
    req_rd_data  = br_rd_data;
    req_rd_data_valid = 2'b00;
    if (state_q == READ && !rst) begin
      req_rd_data_valid[owner_q] = br_rd_data_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          if (req_cmd[grant]) begin
            // Beat 0 goes out with the command; a one-beat burst is then already done.
            if (BURST_COUNT > 1) begin
              state_d = WRITE;
              cnt_d   = CW'(1);
            end else begin
              last_grant_d = grant;
            end
          end else begin
            state_d = READ;
            cnt_d   = '0;
          end
        end
      end
      READ: begin
        if (br_rd_data_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d      = IDLE;
            cnt_d        = '0;
            last_grant_d = owner_q;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BEAT) begin
          state_d      = IDLE;
          cnt_d        = '0;
          last_grant_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: directed scenarios plus randomized two-client
// traffic checked against a transaction-level model of grants and bursts.
module tb_burst_ram_arbiter;

  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BC = 4;
  localparam int MW = DW / 8;

  typedef logic [BC-1:0][DW-1:0] beats_t;
  typedef logic [BC-1:0][MW-1:0] masks_t;

  logic            clk;
  logic            rst;
  logic [1:0]      req_cmd;
  logic [1:0]      req_cmd_en;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wr_data;
  logic [2*MW-1:0] req_data_mask;
  logic [DW-1:0]   req_rd_data;
  logic [1:0]      req_rd_data_valid;
  logic [1:0]      req_busy;
  logic            br_cmd;
  logic            br_cmd_en;
  logic [AW-1:0]   br_addr;
  logic [DW-1:0]   br_wr_data;
  logic [MW-1:0]   br_data_mask;
  logic [DW-1:0]   br_rd_data;
  logic            br_rd_data_valid;
  logic            br_busy;

  int   checks = 0;
  int   errors = 0;
  logic tie_winner;  // client the model expects to win the next tie

  burst_ram_arbiter #(
    .DATA_BITWIDTH (DW),
    .DEPTH_BITWIDTH(AW),
    .BURST_COUNT   (BC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_cmd          (req_cmd),
    .req_cmd_en       (req_cmd_en),
    .req_addr         (req_addr),
    .req_wr_data      (req_wr_data),
    .req_data_mask    (req_data_mask),
    .req_rd_data      (req_rd_data),
    .req_rd_data_valid(req_rd_data_valid),
    .req_busy         (req_busy),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid),
    .br_busy          (br_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_cmd          = '0;
    req_cmd_en       = '0;
    req_addr         = '0;
    req_wr_data      = '0;
    req_data_mask    = '0;
    br_rd_data       = '0;
    br_rd_data_valid = 1'b0;
    br_busy          = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    adv();
    adv();
    rst = 1'b0;
    tie_winner = 1'b0;
  endtask

  // Feeds BC valid beats with random gaps; owner must see every one of them.
  task automatic serve_read(input logic owner);
    int unsigned beat = 0;
    int unsigned gap = 0;
    logic v;
    logic [DW-1:0] d;
    logic [1:0] exp_v;
    while (beat < BC) begin
      v = (gap >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
      d = {$urandom, $urandom};
      br_rd_data_valid = v;
      br_rd_data = d;
      #1;
      exp_v = v ? (owner ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({req_rd_data_valid, req_busy, br_cmd_en} !== {exp_v, 2'b11, 1'b0}) begin
        errors++;
        $display("FAIL read_beat owner=%0d beat=%0d: got valid=%b busy=%b cmd_en=%b, exp valid=%b busy=11 cmd_en=0",
                 owner, beat, req_rd_data_valid, req_busy, br_cmd_en, exp_v);
      end
      if (v) begin
        checks++;
        if (req_rd_data !== d) begin
          errors++;
          $display("FAIL read_data beat=%0d: got %h exp %h", beat, req_rd_data, d);
        end
        beat++;
        gap = 0;
      end else begin
        gap++;
      end
      adv();
    end
    br_rd_data_valid = 1'b0;
    tie_winner = ~owner;
  endtask

  // Beats 1..BC-1 of a write already accepted; other client's slice carries junk.
  task automatic serve_write(input logic owner, input beats_t b, input masks_t m);
    for (int unsigned k = 1; k < BC; k++) begin
      req_wr_data   = {$urandom, $urandom, $urandom, $urandom};
      req_data_mask = 16'($urandom);
      if (owner) begin
        req_wr_data[2*DW-1:DW]   = b[k];
        req_data_mask[2*MW-1:MW] = m[k];
      end else begin
        req_wr_data[DW-1:0]   = b[k];
        req_data_mask[MW-1:0] = m[k];
      end
      br_rd_data_valid = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({br_wr_data, br_data_mask} !== {b[k], m[k]}) begin
        errors++;
        $display("FAIL write_beat owner=%0d beat=%0d: got %h/%h exp %h/%h",
                 owner, k, br_wr_data, br_data_mask, b[k], m[k]);
      end
      checks++;
      if ({req_rd_data_valid, req_busy, br_cmd_en} !== 5'b00_11_0) begin
        errors++;
        $display("FAIL write_status beat=%0d: got valid=%b busy=%b cmd_en=%b exp 00/11/0",
                 k, req_rd_data_valid, req_busy, br_cmd_en);
      end
      adv();
    end
    br_rd_data_valid = 1'b0;
    tie_winner = ~owner;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_cmd_en = 2'b01;
    br_rd_data_valid = 1'b1;
    adv();
    repeat (2) begin
      #1;
      checks++;
      if ({br_cmd_en, req_rd_data_valid, req_busy} !== 5'b0_00_00) begin
        errors++;
        $display("FAIL reset_hold: got cmd_en=%b valid=%b busy=%b exp 0/00/00",
                 br_cmd_en, req_rd_data_valid, req_busy);
      end
      adv();
    end
    rst = 1'b0;
    idle_inputs();
    tie_winner = 1'b0;
    #1;
    checks++;
    if ({br_cmd_en, req_rd_data_valid, req_busy} !== 5'b0_00_00) begin
      errors++;
      $display("FAIL reset_idle: got cmd_en=%b valid=%b busy=%b exp 0/00/00",
               br_cmd_en, req_rd_data_valid, req_busy);
    end
    adv();
  endtask

  task automatic test_single_read();
    req_cmd_en = 2'b01;
    req_cmd = 2'b00;
    req_addr = {8'h00, 8'h10};
    #1;
    checks++;
    if ({br_cmd_en, br_cmd, br_addr, req_busy} !== {1'b1, 1'b0, 8'h10, 2'b00}) begin
      errors++;
      $display("FAIL single_read_accept: got en=%b cmd=%b addr=%h busy=%b exp 1/0/10/00",
               br_cmd_en, br_cmd, br_addr, req_busy);
    end
    adv();
    req_cmd_en = 2'b00;
    serve_read(1'b0);
    #1;
    checks++;
    if ({req_busy, br_cmd_en, req_rd_data_valid} !== 5'b00_0_00) begin
      errors++;
      $display("FAIL single_read_done: got busy=%b cmd_en=%b valid=%b exp 00/0/00",
               req_busy, br_cmd_en, req_rd_data_valid);
    end
    adv();
  endtask

  task automatic test_tie();
    do_reset();
    req_cmd_en = 2'b11;
    req_cmd = 2'b00;
    req_addr = {8'h31, 8'h30};
    #1;
    checks++;
    if ({br_cmd_en, br_addr, req_busy} !== {1'b1, 8'h30, 2'b10}) begin
      errors++;
      $display("FAIL tie_first: got en=%b addr=%h busy=%b exp 1/30/10", br_cmd_en, br_addr, req_busy);
    end
    adv();
    req_cmd_en = 2'b10;
    serve_read(1'b0);
    #1;
    checks++;
    if ({br_cmd_en, br_addr, req_busy} !== {1'b1, 8'h31, 2'b00}) begin
      errors++;
      $display("FAIL tie_held_client1: got en=%b addr=%h busy=%b exp 1/31/00", br_cmd_en, br_addr, req_busy);
    end
    adv();
    req_cmd_en = 2'b00;
    serve_read(1'b1);
    req_cmd_en = 2'b11;
    #1;
    checks++;
    if ({br_cmd_en, br_addr, req_busy} !== {1'b1, 8'h30, 2'b10}) begin
      errors++;
      $display("FAIL tie_second: got en=%b addr=%h busy=%b exp 1/30/10", br_cmd_en, br_addr, req_busy);
    end
    adv();
    req_cmd_en = 2'b00;
    serve_read(1'b0);
  endtask

  task automatic test_write();
    beats_t b;
    masks_t m;
    for (int unsigned k = 0; k < BC; k++) begin
      b[k] = DW'(8'hA0 + k);
      m[k] = 8'hFF;
    end
    req_cmd_en = 2'b10;
    req_cmd = 2'b10;
    req_addr = {8'h20, 8'h5A};
    req_wr_data = {b[0], 64'h1111_2222_3333_4444};
    req_data_mask = {m[0], 8'h0F};
    #1;
    checks++;
    if ({br_cmd_en, br_cmd, br_addr, req_busy} !== {1'b1, 1'b1, 8'h20, 2'b00}) begin
      errors++;
      $display("FAIL write_accept: got en=%b cmd=%b addr=%h busy=%b exp 1/1/20/00",
               br_cmd_en, br_cmd, br_addr, req_busy);
    end
    checks++;
    if ({br_wr_data, br_data_mask} !== {b[0], m[0]}) begin
      errors++;
      $display("FAIL write_beat0: got %h/%h exp %h/%h", br_wr_data, br_data_mask, b[0], m[0]);
    end
    adv();
    req_cmd_en = 2'b00;
    serve_write(1'b1, b, m);
    req_wr_data = {64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF};
    req_data_mask = 16'h3C5A;
    br_rd_data_valid = 1'b1;
    #1;
    checks++;
    if ({req_rd_data_valid, req_busy, br_cmd_en} !== 5'b00_00_0) begin
      errors++;
      $display("FAIL write_done: got valid=%b busy=%b cmd_en=%b exp 00/00/0",
               req_rd_data_valid, req_busy, br_cmd_en);
    end
    checks++;
    if ({br_wr_data, br_data_mask} !== {64'h0123_4567_89AB_CDEF, 8'h5A}) begin
      errors++;
      $display("FAIL idle_data_mux: got %h/%h exp 0123456789abcdef/5a", br_wr_data, br_data_mask);
    end
    adv();
    br_rd_data_valid = 1'b0;
  endtask

  task automatic test_br_busy();
    br_busy = 1'b1;
    req_cmd_en = 2'b01;
    req_cmd = 2'b00;
    req_addr = {8'h00, 8'h44};
    repeat (3) begin
      #1;
      checks++;
      if ({br_cmd_en, req_busy} !== 3'b0_11) begin
        errors++;
        $display("FAIL brbusy_hold: got cmd_en=%b busy=%b exp 0/11", br_cmd_en, req_busy);
      end
      adv();
    end
    br_busy = 1'b0;
    #1;
    checks++;
    if ({br_cmd_en, br_cmd, br_addr, req_busy} !== {1'b1, 1'b0, 8'h44, 2'b00}) begin
      errors++;
      $display("FAIL brbusy_release: got en=%b cmd=%b addr=%h busy=%b exp 1/0/44/00",
               br_cmd_en, br_cmd, br_addr, req_busy);
    end
    adv();
    req_cmd_en = 2'b00;
    serve_read(1'b0);
  endtask

  task automatic test_reset_mid_burst();
    req_cmd_en = 2'b01;
    req_cmd = 2'b00;
    req_addr = {8'h00, 8'h50};
    #1;
    checks++;
    if ({br_cmd_en, br_addr} !== {1'b1, 8'h50}) begin
      errors++;
      $display("FAIL midrst_accept: got en=%b addr=%h exp 1/50", br_cmd_en, br_addr);
    end
    adv();
    req_cmd_en = 2'b00;
    repeat (2) begin
      br_rd_data_valid = 1'b1;
      br_rd_data = {$urandom, $urandom};
      #1;
      checks++;
      if (req_rd_data_valid !== 2'b01) begin
        errors++;
        $display("FAIL midrst_beat: got valid=%b exp 01", req_rd_data_valid);
      end
      adv();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_rd_data_valid, br_cmd_en} !== 3'b00_0) begin
      errors++;
      $display("FAIL midrst_in_reset: got valid=%b cmd_en=%b exp 00/0", req_rd_data_valid, br_cmd_en);
    end
    adv();
    rst = 1'b0;
    tie_winner = 1'b0;
    repeat (2) begin
      #1;
      checks++;
      if ({req_rd_data_valid, req_busy} !== 4'b00_00) begin
        errors++;
        $display("FAIL midrst_stray: got valid=%b busy=%b exp 00/00", req_rd_data_valid, req_busy);
      end
      adv();
    end
    br_rd_data_valid = 1'b0;
    req_cmd_en = 2'b10;
    req_addr = {8'h60, 8'h00};
    #1;
    checks++;
    if ({br_cmd_en, br_cmd, br_addr, req_busy} !== {1'b1, 1'b0, 8'h60, 2'b00}) begin
      errors++;
      $display("FAIL midrst_new_req: got en=%b cmd=%b addr=%h busy=%b exp 1/0/60/00",
               br_cmd_en, br_cmd, br_addr, req_busy);
    end
    adv();
    req_cmd_en = 2'b00;
    serve_read(1'b1);
  endtask

  // Each client holds at most one pending request until the model grants it.
  task automatic test_random();
    logic            has [2];
    logic            cmd_m [2];
    logic [AW-1:0]   addr_m [2];
    beats_t          bt [2];
    masks_t          mk [2];
    int unsigned     w;
    int unsigned     waits;
    logic [1:0]      exp_busy;
    do_reset();
    has[0] = 1'b0;
    has[1] = 1'b0;
    for (int unsigned it = 0; it < 40; it++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (!has[c] && ($urandom_range(0, 1) == 1 || (c == 1 && !has[0]))) begin
          has[c]    = 1'b1;
          cmd_m[c]  = 1'($urandom_range(0, 1));
          addr_m[c] = AW'($urandom);
          for (int unsigned k = 0; k < BC; k++) begin
            bt[c][k] = {$urandom, $urandom};
            mk[c][k] = MW'($urandom);
          end
        end
      end
      for (int unsigned c = 0; c < 2; c++) begin
        req_cmd_en[c] = has[c];
        req_cmd[c] = cmd_m[c];
        req_addr[c*AW +: AW] = addr_m[c];
        req_wr_data[c*DW +: DW] = bt[c][0];
        req_data_mask[c*MW +: MW] = mk[c][0];
      end
      waits = $urandom_range(0, 2);
      repeat (waits) begin
        br_busy = 1'b1;
        br_rd_data_valid = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if ({br_cmd_en, req_busy, req_rd_data_valid} !== 5'b0_11_00) begin
          errors++;
          $display("FAIL rand_brbusy it=%0d: got en=%b busy=%b valid=%b exp 0/11/00",
                   it, br_cmd_en, req_busy, req_rd_data_valid);
        end
        adv();
      end
      br_busy = 1'b0;
      br_rd_data_valid = 1'b0;
      if (has[0] && has[1]) begin
        w = tie_winner ? 1 : 0;
        exp_busy = tie_winner ? 2'b01 : 2'b10;
      end else begin
        w = has[0] ? 0 : 1;
        exp_busy = 2'b00;
      end
      #1;
      checks++;
      if ({br_cmd_en, br_cmd, br_addr, req_busy} !== {1'b1, cmd_m[w], addr_m[w], exp_busy}) begin
        errors++;
        $display("FAIL rand_grant it=%0d: got en=%b cmd=%b addr=%h busy=%b exp 1/%b/%h/%b",
                 it, br_cmd_en, br_cmd, br_addr, req_busy, cmd_m[w], addr_m[w], exp_busy);
      end
      if (cmd_m[w]) begin
        checks++;
        if ({br_wr_data, br_data_mask} !== {bt[w][0], mk[w][0]}) begin
          errors++;
          $display("FAIL rand_wbeat0 it=%0d: got %h/%h exp %h/%h",
                   it, br_wr_data, br_data_mask, bt[w][0], mk[w][0]);
        end
      end
      has[w] = 1'b0;
      adv();
      req_cmd_en[w] = 1'b0;
      if (cmd_m[w]) serve_write(1'(w), bt[w], mk[w]);
      else          serve_read(1'(w));
    end
    idle_inputs();
    adv();
  endtask

  initial begin
    rst = 1'b1;
    tie_winner = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_br_busy();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
